// File: rtl/if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// if_prefetch_unit
// Instruction-fetch prefetcher. Issues sequential fetch requests (one
// outstanding at a time) into a small FIFO of {fetch address, instruction}
// entries and hands the FIFO head to the decode stage. A redirect (PC_src)
// flushes the queue, reloads the fetch PC and discards any in-flight response.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   PC_src         : redirect request (flush + reload fetch PC)
//   PC_branch      : redirect target address
//   mem_rd_en      : one-cycle fetch request pulse (combinational)
//   mem_addr       : fetch address, valid while mem_rd_en=1
//   mem_rdata      : returned instruction
//   mem_rvalid     : mem_rdata valid (one response per request)
//   instr_valid    : queue head valid (combinational, masked by PC_src)
//   instr_ready    : consumer accepts the head entry
//   instruction    : head instruction
//   PC_out         : fetch address of head instruction
//   occupancy      : number of queued entries
// -----------------------------------------------------------------------------
module if_prefetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned PC_INC   = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       PC_src,
    input  logic [ADDR_W-1:0]          PC_branch,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [INSTR_W-1:0]         mem_rdata,
    input  logic                       mem_rvalid,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [INSTR_W-1:0]         instruction,
    output logic [ADDR_W-1:0]          PC_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e               state_q,    state_d;
    logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [OCC_W-1:0]     occ_q,      occ_d;
    logic [INSTR_W-1:0]   instr_mem_q [DEPTH];
    logic [INSTR_W-1:0]   instr_mem_d [DEPTH];
    logic [ADDR_W-1:0]    pc_mem_q    [DEPTH];
    logic [ADDR_W-1:0]    pc_mem_d    [DEPTH];

    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 space_after_push;

    // Head is presentable only when queued and not being flushed this cycle.
    assign instr_valid = (occ_q != '0) & ~PC_src;
    assign pop         = instr_valid & instr_ready;
    assign instruction = instr_mem_q[rd_ptr_q];
    assign PC_out      = pc_mem_q[rd_ptr_q];
    assign occupancy   = occ_q;
    assign mem_addr    = fetch_pc_q;
    // Reset masks the request pulse even though the FSM already sits in IDLE.
    assign mem_rd_en   = issue & rst_n;

    // Room for another entry once this cycle's push and pop have both landed.
    // occ_q >= pop always holds, since pop requires a non-empty queue.
    assign space_after_push = (occ_q - OCC_W'(pop)) < OCC_W'(DEPTH - 1);

    // Next-state, issue decision and queue update.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        issue       = 1'b0;
        push        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!PC_src && (occ_q < OCC_W'(DEPTH))) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (PC_src) begin
                    // Response arriving with the redirect is simply dropped.
                    state_d = mem_rvalid ? ST_IDLE : ST_DISCARD;
                end else if (mem_rvalid) begin
                    push = 1'b1;
                    if (space_after_push) begin
                        issue = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DISCARD: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Fetch PC: redirect wins, otherwise advance on every issued request.
        if (PC_src) begin
            fetch_pc_d = PC_branch;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
        end
        if (issue) begin
            req_addr_d = fetch_pc_q;
        end

        if (PC_src) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = mem_rdata;
                pc_mem_d[wr_ptr_q]    = req_addr_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // State and queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= ADDR_W'(RESET_PC);
            req_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

endmodule
